// File: rtl/accu_result_drain.sv
// Drains accumulator sums: padding-row drop, bias, ReLU, round/saturate to int8, 4:1 pack, word FIFO.
// Word reaches m_valid 3 edges after its 4th pixel is sampled; no upstream backpressure, drops on full FIFO.

module accu_result_drain_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module accu_result_drain #(
    parameter int COL_NUM    = 128,
    parameter int ROW_NUM    = 128,
    parameter int PAD_ROWS   = 1,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic signed [17:0] din,
    input  logic signed [17:0] bias,
    input  logic               relu_en,
    input  logic               clear_ovf,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [31:0]        m_data,
    output logic               m_last,
    output logic               frame_done,
    output logic               overflow
);
    localparam int FRAME_ROWS = ROW_NUM + 2*PAD_ROWS;
    localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int RW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam logic [19:0] RND = 20'(1 << (SHIFT-1));

    // Raster position
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          first_px;
    logic          col_last;
    logic          row_last;
    logic          kept;
    logic          last_kept;

    assign first_px  = (col == '0) && (row == '0);
    assign col_last  = (col == CW'(COL_NUM-1));
    assign row_last  = (row == RW'(FRAME_ROWS-1));
    assign kept      = (row >= RW'(PAD_ROWS)) && (row < RW'(PAD_ROWS+ROW_NUM));
    assign last_kept = col_last && (row == RW'(PAD_ROWS+ROW_NUM-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Frame parameters: the frame's first pixel already uses the freshly sampled values.
    logic signed [17:0] bias_q;
    logic               relu_q;
    logic signed [17:0] bias_eff;
    logic               relu_eff;

    assign bias_eff = first_px ? bias : bias_q;
    assign relu_eff = first_px ? relu_en : relu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
            relu_q <= 1'b0;
        end else if (valid_in && first_px) begin
            bias_q <= bias;
            relu_q <= relu_en;
        end
    end

    // S1: bias add
    logic               s1_vld;
    logic               s1_last;
    logic               s1_relu;
    logic signed [18:0] s1_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_relu <= 1'b0;
            s1_sum  <= '0;
        end else begin
            s1_vld <= valid_in && kept;
            if (valid_in && kept) begin
                s1_last <= last_kept;
                s1_relu <= relu_eff;
                s1_sum  <= {din[17], din} + {bias_eff[17], bias_eff};
            end
        end
    end

    // S2: ReLU, round-half-up arithmetic shift, saturate to int8
    logic signed [18:0] relu_val;
    logic signed [19:0] rnd;
    logic signed [19:0] shr;
    logic [7:0]         byte_nxt;
    logic               s2_vld;
    logic               s2_last;
    logic [7:0]         s2_byte;

    always_comb begin
        relu_val = s1_sum;
        if (s1_relu && s1_sum[18]) relu_val = '0;
        // One guard bit so the rounding constant cannot wrap the largest sum.
        rnd = {relu_val[18], relu_val} + RND;
        shr = rnd >>> SHIFT;
        if (shr > 20'sd127)       byte_nxt = 8'h7f;
        else if (shr < -20'sd128) byte_nxt = 8'h80;
        else                      byte_nxt = shr[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_byte <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_last <= s1_last;
                s2_byte <= byte_nxt;
            end
        end
    end

    // S3: pack four bytes, first pixel in the low byte
    logic [1:0]  lane;
    logic [23:0] pack;
    logic        push_q;
    logic [31:0] push_word;
    logic        push_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            pack      <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
            push_last <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (s2_vld) begin
                lane <= lane + 1'b1;
                case (lane)
                    2'd0:    pack[7:0]   <= s2_byte;
                    2'd1:    pack[15:8]  <= s2_byte;
                    2'd2:    pack[23:16] <= s2_byte;
                    default: begin
                        push_q    <= 1'b1;
                        push_word <= {s2_byte, pack};
                        push_last <= s2_last;
                    end
                endcase
            end
        end
    end

    // Output word FIFO
    logic [32:0] fifo_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    accu_result_drain_fifo #(
        .W     (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_q),
        .push_dat ({push_last, push_word}),
        .pop      (pop),
        .pop_dat  (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    // Stale FIFO contents are masked so the port reads zero whenever nothing is offered.
    assign m_data  = m_valid ? fifo_out[31:0] : 32'h0;
    assign m_last  = m_valid && fifo_out[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && m_last;
            if (clear_ovf)
                overflow <= 1'b0;
            else if (push_q && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_accu_result_drain.sv
// Directed bench for accu_result_drain with a 4x2 kept frame, one padding row each side, 2-word FIFO.
module tb_accu_result_drain;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic signed [17:0] din = '0;
    logic signed [17:0] bias = '0;
    logic               relu_en = 1'b0;
    logic               clear_ovf = 1'b0;
    logic               m_ready = 1'b0;
    logic               m_valid;
    logic [31:0]        m_data;
    logic               m_last;
    logic               frame_done;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    int          fd_cnt = 0;
    int          fd_bad = 0;
    logic        prev_pop_last = 1'b0;

    always #5 clk = ~clk;

    accu_result_drain #(
        .COL_NUM    (4),
        .ROW_NUM    (2),
        .PAD_ROWS   (1),
        .SHIFT      (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .din        (din),
        .bias       (bias),
        .relu_en    (relu_en),
        .clear_ovf  (clear_ovf),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    // Inputs change on the falling edge; the port is observed 2 time units before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (frame_done) fd_cnt++;
                if (frame_done !== prev_pop_last) fd_bad++;
                if (m_valid && m_ready) begin
                    got_data.push_back(m_data);
                    got_last.push_back(m_last);
                end
                prev_pop_last = m_valid && m_ready && m_last;
            end else begin
                prev_pop_last = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [31:0] wd, input logic lst);
        logic [31:0] d;
        logic        l;
        d = (idx < got_data.size()) ? got_data[idx] : 32'hxxxxxxxx;
        l = (idx < got_last.size()) ? got_last[idx] : 1'bx;
        chk({tag, "_data"}, d, wd);
        chk({tag, "_last"}, 32'(l), 32'(lst));
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        chk({tag, "_count"}, 32'(got_data.size()), 32'd2);
        chk_got({tag, "_w0"}, 0, w0, 1'b0);
        chk_got({tag, "_w1"}, 1, w1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int d);
        valid_in = 1'b1;
        din      = 18'(d);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_row(input int a, input int b, input int c, input int d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d);
        send_row(999, 999, 999, 999);
        send_row(a, b, c, d);
        send_row(a, b, c, d);
        send_row(999, 999, 999, 999);
    endtask

    initial begin
        idle(2);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Plain frame, padding rows carry 999
        m_ready = 1'b1;
        send_frame(32, 32, 32, 32);
        idle(6);
        chk_frame("t1", 32'h02020202, 32'h02020202);
        chk("t1_frame_done_cnt", 32'(fd_cnt), 32'd1);
        chk("t1_m_valid", 32'(m_valid), 32'd0);

        // Rounding of negatives and saturation both ways
        got_data.delete(); got_last.delete();
        send_frame(24, -24, 4000, -4000);
        idle(6);
        chk_frame("t2", 32'h807FFF02, 32'h807FFF02);

        // ReLU with negative bias; bias/relu change after the first pixel is ignored this frame
        got_data.delete(); got_last.delete();
        bias = -18'sd40;
        relu_en = 1'b1;
        send(999);
        bias = 18'sd1000;
        relu_en = 1'b0;
        send(999); send(999); send(999);
        send_row(56, -24, 8, -200);
        send_row(56, -24, 8, -200);
        send_row(999, 999, 999, 999);
        idle(6);
        chk_frame("t3", 32'h00000001, 32'h00000001);

        // The new bias takes effect on the next frame: (0+1000+8)>>4 = 63
        got_data.delete(); got_last.delete();
        send_frame(0, 0, 0, 0);
        idle(6);
        chk_frame("t3b", 32'h3F3F3F3F, 32'h3F3F3F3F);
        bias = '0;

        // Stalled downstream: second frame's words are dropped
        got_data.delete(); got_last.delete();
        m_ready = 1'b0;
        send_frame(32, 32, 32, 32);
        idle(6);
        chk("t4_held_valid", 32'(m_valid), 32'd1);
        chk("t4_held_ovf", 32'(overflow), 32'd0);
        chk("t4_held_data", m_data, 32'h02020202);
        send_frame(48, 48, 48, 48);
        idle(6);
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        m_ready = 1'b1;
        idle(6);
        chk_frame("t4_drain", 32'h02020202, 32'h02020202);
        chk("t4_empty", 32'(m_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        idle(1);
        clear_ovf = 1'b0;
        chk("t4_ovf_clear", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full
        got_data.delete(); got_last.delete();
        m_ready = 1'b0;
        send_row(999, 999, 999, 999);
        send_row(32, 32, 32, 32);
        send_row(48, 48, 48, 48);
        send_row(999, 999, 999, 999);
        idle(6);
        chk("t5_full_head", m_data, 32'h02020202);
        send_row(999, 999, 999, 999);
        send_row(64, 64, 64, 64);
        idle(2);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_head_after", m_data, 32'h03030303);
        chk("t5_head_last", 32'(m_last), 32'd1);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        chk("t5_next_head", m_data, 32'h04040404);
        m_ready = 1'b1;
        send_row(80, 80, 80, 80);
        send_row(999, 999, 999, 999);
        idle(6);
        chk("t5_count", 32'(got_data.size()), 32'd4);
        chk_got("t5_w0", 0, 32'h02020202, 1'b0);
        chk_got("t5_w1", 1, 32'h03030303, 1'b1);
        chk_got("t5_w2", 2, 32'h04040404, 1'b0);
        chk_got("t5_w3", 3, 32'h05050505, 1'b1);
        chk("t5_ovf_end", 32'(overflow), 32'd0);

        // Reset in the middle of a frame with a full FIFO and overflow set
        m_ready = 1'b0;
        send_frame(32, 32, 32, 32);
        send_frame(32, 32, 32, 32);
        send_row(999, 999, 999, 999);
        send(32);
        send(32);
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        chk("t6_pre_ovf", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_m_data", m_data, 32'h0);
        chk("t6_rst_m_last", 32'(m_last), 32'd0);
        chk("t6_rst_frame_done", 32'(frame_done), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        got_data.delete(); got_last.delete();
        m_ready = 1'b1;
        send_frame(32, 32, 32, 32);
        idle(6);
        chk_frame("t6", 32'h02020202, 32'h02020202);

        chk("frame_done_alignment", 32'(fd_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
